id_ex_pipe_reg: RTL and testbench

ID/EX pipeline register of the 5-stage pipelined CPU, directly upstream of the ALU. It latches decoded operands and control from the decode stage. It handles stall (hold) and flush (bubble insertion), and presents ALU-ready operands (alu_in_1, alu_in_2) plus the ALU operation code to the execute stage. It also keeps a saturating bubble counter for performance debug.

---
 rtl/id_ex_pipe_reg_pkg.sv | 35 +++
 rtl/id_ex_pipe_reg_if.sv | 70 +++++++
 rtl/id_ex_pipe_reg_fwd_operand_mux.sv | 37 +++
 rtl/id_ex_pipe_reg.sv | 134 +++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared widths, ALU function codes and control payload for the ID/EX stage.
package id_ex_pipe_reg_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_ALU_OP_WIDTH   = 4;
  localparam int unsigned DEF_REG_ADDR_WIDTH = 5;
  localparam int unsigned DEF_CNT_WIDTH      = 16;

  // FUNC_ZERO doubles as the bubble op so a cleared register is a valid no-op.
  typedef enum logic [DEF_ALU_OP_WIDTH-1:0] {
    FUNC_ZERO   = 4'h0,
    FUNC_ADD    = 4'h1,
    FUNC_SUB    = 4'h2,
    FUNC_AND    = 4'h3,
    FUNC_OR     = 4'h4,
    FUNC_XOR    = 4'h5,
    FUNC_SLL    = 4'h6,
    FUNC_SRL    = 4'h7,
    FUNC_SRA    = 4'h8,
    FUNC_SLT    = 4'h9,
    FUNC_SLTU   = 4'hA,
    FUNC_PASS_B = 4'hB
  } alu_func_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic is_halt;
  } ex_ctrl_t;

  localparam ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// Decode-side, forwarding and execute-side signals of the ID/EX pipeline register.
interface id_ex_pipe_reg_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ALU_OP_WIDTH   = 4,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 16
);
  logic                      stall;
  logic                      flush;
  logic                      in_valid;
  logic [DATA_WIDTH-1:0]     id_pc;
  logic [DATA_WIDTH-1:0]     id_rs1_data;
  logic [DATA_WIDTH-1:0]     id_rs2_data;
  logic [DATA_WIDTH-1:0]     id_imm;
  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rd_addr;
  logic [ALU_OP_WIDTH-1:0]   id_alu_op;
  logic                      id_alu_src;
  logic                      id_reg_write;
  logic                      id_mem_read;
  logic                      id_mem_write;
  logic                      id_mem_to_reg;
  logic                      id_is_halt;

  logic                      fwd_exmem_we;
  logic                      fwd_memwb_we;
  logic [REG_ADDR_WIDTH-1:0] fwd_exmem_rd;
  logic [REG_ADDR_WIDTH-1:0] fwd_memwb_rd;
  logic [DATA_WIDTH-1:0]     fwd_exmem_data;
  logic [DATA_WIDTH-1:0]     fwd_memwb_data;

  logic                      ex_valid;
  logic [DATA_WIDTH-1:0]     ex_pc;
  logic [ALU_OP_WIDTH-1:0]   ex_alu_op;
  logic [DATA_WIDTH-1:0]     ex_alu_in_1;
  logic [DATA_WIDTH-1:0]     ex_alu_in_2;
  logic [DATA_WIDTH-1:0]     ex_store_data;
  logic [REG_ADDR_WIDTH-1:0] ex_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] ex_rs2_addr;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr;
  logic                      ex_reg_write;
  logic                      ex_mem_read;
  logic                      ex_mem_write;
  logic                      ex_mem_to_reg;
  logic                      ex_is_halt;
  logic [CNT_WIDTH-1:0]      bubble_count;

  modport master (
    output stall, flush, in_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_op, id_alu_src,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_is_halt,
           fwd_exmem_we, fwd_memwb_we, fwd_exmem_rd, fwd_memwb_rd,
           fwd_exmem_data, fwd_memwb_data,
    input  ex_valid, ex_pc, ex_alu_op, ex_alu_in_1, ex_alu_in_2, ex_store_data,
           ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_mem_to_reg, ex_is_halt, bubble_count
  );

  modport slave (
    input  stall, flush, in_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_op, id_alu_src,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_is_halt,
           fwd_exmem_we, fwd_memwb_we, fwd_exmem_rd, fwd_memwb_rd,
           fwd_exmem_data, fwd_memwb_data,
    output ex_valid, ex_pc, ex_alu_op, ex_alu_in_1, ex_alu_in_2, ex_store_data,
           ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_mem_to_reg, ex_is_halt, bubble_count
  );
endinterface

// File: rtl/id_ex_pipe_reg_fwd_operand_mux.sv
// Resolves one EX operand against the EX/MEM and MEM/WB writebacks.
// Forwarding is compiled in only when FORWARDING_EN is defined.
module fwd_operand_mux #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_addr,
  input  logic [DATA_WIDTH-1:0]     rs_data,
  input  logic                      exmem_we,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_data,
  input  logic                      memwb_we,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_data,
  output logic [DATA_WIDTH-1:0]     rs_eff
);

`ifdef FORWARDING_EN
  // Youngest producer wins; x0 is hardwired and never forwarded.
  always_comb begin
    rs_eff = rs_data;
    if (rs_addr != '0) begin
      if (exmem_we && (exmem_rd == rs_addr)) begin
        rs_eff = exmem_data;
      end else if (memwb_we && (memwb_rd == rs_addr)) begin
        rs_eff = memwb_data;
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{rs_addr, exmem_we, exmem_rd, exmem_data,
                        memwb_we, memwb_rd, memwb_data};
  assign rs_eff     = rs_data;
`endif

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: stall/flush handling, ALU operand selection, bubble counter.
// Optional operand forwarding is enabled by the FORWARDING_EN macro.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned ALU_OP_WIDTH   = DEF_ALU_OP_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input logic             clk,
  input logic             reset,
  id_ex_pipe_reg_if.slave bus
);

  logic                      valid_q;
  logic [DATA_WIDTH-1:0]     pc_q;
  logic [DATA_WIDTH-1:0]     rs1_data_q;
  logic [DATA_WIDTH-1:0]     rs2_data_q;
  logic [DATA_WIDTH-1:0]     imm_q;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr_q;
  logic [REG_ADDR_WIDTH-1:0] rs2_addr_q;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
  logic [ALU_OP_WIDTH-1:0]   alu_op_q;
  logic                      alu_src_q;
  ex_ctrl_t                  ctrl_q;
  logic [CNT_WIDTH-1:0]      bubble_q;
  logic [CNT_WIDTH-1:0]      bubble_inc;
  logic [DATA_WIDTH-1:0]     rs1_eff;
  logic [DATA_WIDTH-1:0]     rs2_eff;

  // Saturating increment: holds at all-ones instead of wrapping.
  assign bubble_inc = (bubble_q == '1) ? bubble_q : bubble_q + CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      alu_op_q   <= ALU_OP_WIDTH'(FUNC_ZERO);
      alu_src_q  <= 1'b0;
      ctrl_q     <= CTRL_BUBBLE;
      bubble_q   <= '0;
    end else if (bus.flush) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      alu_op_q   <= ALU_OP_WIDTH'(FUNC_ZERO);
      alu_src_q  <= 1'b0;
      ctrl_q     <= CTRL_BUBBLE;
      bubble_q   <= bubble_inc;
    end else if (!bus.stall) begin
      valid_q    <= bus.in_valid;
      pc_q       <= bus.id_pc;
      rs1_data_q <= bus.id_rs1_data;
      rs2_data_q <= bus.id_rs2_data;
      imm_q      <= bus.id_imm;
      rs1_addr_q <= bus.id_rs1_addr;
      rs2_addr_q <= bus.id_rs2_addr;
      rd_addr_q  <= bus.id_rd_addr;
      if (bus.in_valid) begin
        alu_op_q  <= bus.id_alu_op;
        alu_src_q <= bus.id_alu_src;
        ctrl_q    <= '{reg_write:  bus.id_reg_write,
                       mem_read:   bus.id_mem_read,
                       mem_write:  bus.id_mem_write,
                       mem_to_reg: bus.id_mem_to_reg,
                       is_halt:    bus.id_is_halt};
      end else begin
        alu_op_q  <= ALU_OP_WIDTH'(FUNC_ZERO);
        alu_src_q <= 1'b0;
        ctrl_q    <= CTRL_BUBBLE;
        bubble_q  <= bubble_inc;
      end
    end
  end

  fwd_operand_mux #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_rs1 (
    .rs_addr    (rs1_addr_q),
    .rs_data    (rs1_data_q),
    .exmem_we   (bus.fwd_exmem_we),
    .exmem_rd   (bus.fwd_exmem_rd),
    .exmem_data (bus.fwd_exmem_data),
    .memwb_we   (bus.fwd_memwb_we),
    .memwb_rd   (bus.fwd_memwb_rd),
    .memwb_data (bus.fwd_memwb_data),
    .rs_eff     (rs1_eff)
  );

  fwd_operand_mux #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_rs2 (
    .rs_addr    (rs2_addr_q),
    .rs_data    (rs2_data_q),
    .exmem_we   (bus.fwd_exmem_we),
    .exmem_rd   (bus.fwd_exmem_rd),
    .exmem_data (bus.fwd_exmem_data),
    .memwb_we   (bus.fwd_memwb_we),
    .memwb_rd   (bus.fwd_memwb_rd),
    .memwb_data (bus.fwd_memwb_data),
    .rs_eff     (rs2_eff)
  );

  assign bus.ex_valid      = valid_q;
  assign bus.ex_pc         = pc_q;
  assign bus.ex_alu_op     = alu_op_q;
  assign bus.ex_alu_in_1   = rs1_eff;
  assign bus.ex_alu_in_2   = alu_src_q ? imm_q : rs2_eff;
  assign bus.ex_store_data = rs2_eff;
  assign bus.ex_rs1_addr   = rs1_addr_q;
  assign bus.ex_rs2_addr   = rs2_addr_q;
  assign bus.ex_rd_addr    = rd_addr_q;
  assign bus.ex_reg_write  = ctrl_q.reg_write;
  assign bus.ex_mem_read   = ctrl_q.mem_read;
  assign bus.ex_mem_write  = ctrl_q.mem_write;
  assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.ex_is_halt    = ctrl_q.is_halt;
  assign bus.bubble_count  = bubble_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg; a second instance with CNT_WIDTH=2 covers saturation.
module tb_id_ex_pipe_reg;
  import id_ex_pipe_reg_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] store;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rda;
    logic [4:0]  ctrl;
    logic [15:0] bubble;
  } out_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  out_t sb[$];
  int   sb_cnt[$];
  out_t obs;
  out_t exp;
  out_t snap;

  // Reference state of the stage.
  logic        m_valid;
  logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
  logic [4:0]  m_rs1a, m_rs2a, m_rda, m_ctrl;
  logic [3:0]  m_op;
  logic        m_src;
  logic [15:0] m_bub;

  id_ex_pipe_reg_if #(.DATA_WIDTH(32), .ALU_OP_WIDTH(4), .REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) bus ();
  id_ex_pipe_reg_if #(.DATA_WIDTH(32), .ALU_OP_WIDTH(4), .REG_ADDR_WIDTH(5), .CNT_WIDTH(2))  bus_s ();

  id_ex_pipe_reg #(.DATA_WIDTH(32), .ALU_OP_WIDTH(4), .REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  id_ex_pipe_reg #(.DATA_WIDTH(32), .ALU_OP_WIDTH(4), .REG_ADDR_WIDTH(5), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .bus(bus_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] resolve(input logic [4:0] a, input logic [31:0] d);
`ifdef FORWARDING_EN
    if (a != 5'd0 && bus.fwd_exmem_we && bus.fwd_exmem_rd == a) return bus.fwd_exmem_data;
    if (a != 5'd0 && bus.fwd_memwb_we && bus.fwd_memwb_rd == a) return bus.fwd_memwb_data;
`endif
    return d;
  endfunction

  function automatic out_t model_out();
    out_t o;
    o.valid  = m_valid;
    o.pc     = m_pc;
    o.alu_op = m_op;
    o.in1    = resolve(m_rs1a, m_rs1);
    o.store  = resolve(m_rs2a, m_rs2);
    o.in2    = m_src ? m_imm : o.store;
    o.rs1a   = m_rs1a;
    o.rs2a   = m_rs2a;
    o.rda    = m_rda;
    o.ctrl   = m_ctrl;
    o.bubble = m_bub;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.valid  = bus.ex_valid;
    o.pc     = bus.ex_pc;
    o.alu_op = bus.ex_alu_op;
    o.in1    = bus.ex_alu_in_1;
    o.in2    = bus.ex_alu_in_2;
    o.store  = bus.ex_store_data;
    o.rs1a   = bus.ex_rs1_addr;
    o.rs2a   = bus.ex_rs2_addr;
    o.rda    = bus.ex_rd_addr;
    o.ctrl   = {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg, bus.ex_is_halt};
    o.bubble = bus.bubble_count;
    return o;
  endfunction

  task automatic model_clear(input logic keep_bub);
    m_valid = 1'b0; m_pc = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0;
    m_rs1a = '0; m_rs2a = '0; m_rda = '0; m_ctrl = '0; m_op = 4'(FUNC_ZERO); m_src = 1'b0;
    if (!keep_bub) m_bub = '0;
  endtask

  task automatic bump();
    if (m_bub != 16'hFFFF) m_bub = m_bub + 16'd1;
  endtask

  // Applies one clock edge: updates the reference, pushes the expectation, advances.
  task automatic step();
    if (bus.flush) begin
      model_clear(1'b1);
      bump();
    end else if (!bus.stall) begin
      m_valid = bus.in_valid; m_pc = bus.id_pc; m_rs1 = bus.id_rs1_data; m_rs2 = bus.id_rs2_data;
      m_imm = bus.id_imm; m_rs1a = bus.id_rs1_addr; m_rs2a = bus.id_rs2_addr; m_rda = bus.id_rd_addr;
      if (bus.in_valid) begin
        m_op = bus.id_alu_op; m_src = bus.id_alu_src;
        m_ctrl = {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_mem_to_reg, bus.id_is_halt};
      end else begin
        m_op = 4'(FUNC_ZERO); m_src = 1'b0; m_ctrl = '0;
        bump();
      end
    end
    sb.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    bus.stall = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b0;
    bus.id_pc = '0; bus.id_rs1_data = '0; bus.id_rs2_data = '0; bus.id_imm = '0;
    bus.id_rs1_addr = '0; bus.id_rs2_addr = '0; bus.id_rd_addr = '0; bus.id_alu_op = '0;
    bus.id_alu_src = 1'b0; bus.id_reg_write = 1'b0; bus.id_mem_read = 1'b0;
    bus.id_mem_write = 1'b0; bus.id_mem_to_reg = 1'b0; bus.id_is_halt = 1'b0;
    bus.fwd_exmem_we = 1'b0; bus.fwd_memwb_we = 1'b0; bus.fwd_exmem_rd = '0; bus.fwd_memwb_rd = '0;
    bus.fwd_exmem_data = '0; bus.fwd_memwb_data = '0;
    bus_s.stall = 1'b1; bus_s.flush = 1'b0; bus_s.in_valid = 1'b0;
    bus_s.id_pc = '0; bus_s.id_rs1_data = '0; bus_s.id_rs2_data = '0; bus_s.id_imm = '0;
    bus_s.id_rs1_addr = '0; bus_s.id_rs2_addr = '0; bus_s.id_rd_addr = '0; bus_s.id_alu_op = '0;
    bus_s.id_alu_src = 1'b0; bus_s.id_reg_write = 1'b0; bus_s.id_mem_read = 1'b0;
    bus_s.id_mem_write = 1'b0; bus_s.id_mem_to_reg = 1'b0; bus_s.id_is_halt = 1'b0;
    bus_s.fwd_exmem_we = 1'b0; bus_s.fwd_memwb_we = 1'b0; bus_s.fwd_exmem_rd = '0;
    bus_s.fwd_memwb_rd = '0; bus_s.fwd_exmem_data = '0; bus_s.fwd_memwb_data = '0;
  endtask

  task automatic random_id(input logic valid);
    bus.in_valid      = valid;
    bus.id_pc         = $urandom;
    bus.id_rs1_data   = $urandom;
    bus.id_rs2_data   = $urandom;
    bus.id_imm        = $urandom;
    bus.id_rs1_addr   = 5'($urandom_range(0, 7));
    bus.id_rs2_addr   = 5'($urandom_range(0, 7));
    bus.id_rd_addr    = 5'($urandom_range(0, 31));
    bus.id_alu_op     = 4'($urandom_range(0, 11));
    bus.id_alu_src    = valid ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.id_reg_write  = 1'($urandom_range(0, 1));
    bus.id_mem_read   = 1'($urandom_range(0, 1));
    bus.id_mem_write  = 1'($urandom_range(0, 1));
    bus.id_mem_to_reg = 1'($urandom_range(0, 1));
    bus.id_is_halt    = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    reset = 1'b0;
    zero_inputs();
    random_id(1'b1);
    repeat (2) @(posedge clk);
    #1;
    model_clear(1'b0);
    sb.push_back(model_out());
    exp = sb.pop_front(); obs = sample(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_state obs=%h exp=%h", obs, exp); end
    checks++;
    if (bus.ex_alu_op !== 4'(FUNC_ZERO)) begin errors++; $display("FAIL reset_alu_op obs=%h exp=%h", bus.ex_alu_op, 4'(FUNC_ZERO)); end
    @(negedge clk);
    reset = 1'b1;
    step();
    exp = sb.pop_front(); obs = sample(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_release obs=%h exp=%h", obs, exp); end
    checks++;
    if (bus_s.bubble_count !== 2'd0) begin errors++; $display("FAIL reset_sat_count obs=%0d exp=0", bus_s.bubble_count); end
    // Load something non-zero, then drop reset between edges while flush/stall are up.
    bus.stall = 1'b0;
    random_id(1'b1);
    bus.id_pc = 32'h0000_0400;
    step();
    exp = sb.pop_front(); obs = sample(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL async_preload obs=%h exp=%h", obs, exp); end
    bus.flush = 1'b1; bus.stall = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_clear(1'b0);
    sb.push_back(model_out());
    exp = sb.pop_front(); obs = sample(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL async_reset obs=%h exp=%h", obs, exp); end
    #1;
    reset = 1'b1;
    bus.flush = 1'b0;
  endtask

  task automatic test_load();
    zero_inputs();
    bus.stall = 1'b0;
    bus.in_valid = 1'b1; bus.id_pc = 32'h100; bus.id_rs1_data = 32'h10; bus.id_rs2_data = 32'h20;
    bus.id_imm = 32'h4; bus.id_alu_src = 1'b1; bus.id_alu_op = 4'(FUNC_ADD); bus.id_reg_write = 1'b1;
    bus.id_rs1_addr = 5'd1; bus.id_rs2_addr = 5'd2; bus.id_rd_addr = 5'd3;
    step();
    exp = sb.pop_front(); obs = sample(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL load obs=%h exp=%h", obs, exp); end
    checks++;
    if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL load_valid obs=%b exp=1", bus.ex_valid); end
    checks++;
    if (bus.ex_alu_in_1 !== 32'h10) begin errors++; $display("FAIL load_in1 obs=%h exp=10", bus.ex_alu_in_1); end
    checks++;
    if (bus.ex_alu_in_2 !== 32'h4) begin errors++; $display("FAIL load_in2 obs=%h exp=4", bus.ex_alu_in_2); end
    checks++;
    if (bus.ex_reg_write !== 1'b1) begin errors++; $display("FAIL load_reg_write obs=%b exp=1", bus.ex_reg_write); end
  endtask

  task automatic test_stall();
    logic [15:0] bub_before;
    snap = sample();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      random_id(1'b1);
      step();
      exp = sb.pop_front(); obs = sample(); checks++;
      if (obs !== exp || obs !== snap) begin
        errors++; $display("FAIL stall_hold[%0d] obs=%h exp=%h", i, obs, exp);
      end
    end
    bub_before = m_bub;
    bus.flush = 1'b1;
    step();
    exp = sb.pop_front(); obs = sample(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL stall_flush obs=%h exp=%h", obs, exp); end
    checks++;
    if (bus.bubble_count !== bub_before + 16'd1 || bus.ex_valid !== 1'b0) begin
      errors++; $display("FAIL flush_bubble obs=%0d/%b exp=%0d/0", bus.bubble_count, bus.ex_valid, bub_before + 16'd1);
    end
    bus.flush = 1'b0; bus.stall = 1'b0;
  endtask

  task automatic test_forwarding();
    logic [31:0] want;
    zero_inputs();
    bus.stall = 1'b0;
    bus.in_valid = 1'b1; bus.id_rs1_addr = 5'd5; bus.id_rs1_data = 32'h11;
    bus.id_rs2_addr = 5'd6; bus.id_rs2_data = 32'h22; bus.id_alu_op = 4'(FUNC_ADD);
    bus.fwd_exmem_we = 1'b1; bus.fwd_exmem_rd = 5'd5; bus.fwd_exmem_data = 32'hAA;
    bus.fwd_memwb_we = 1'b1; bus.fwd_memwb_rd = 5'd5; bus.fwd_memwb_data = 32'hBB;
    step();
    exp = sb.pop_front(); obs = sample(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL fwd_load obs=%h exp=%h", obs, exp); end
`ifdef FORWARDING_EN
    want = 32'hAA;
`else
    want = 32'h11;
`endif
    checks++;
    if (bus.ex_alu_in_1 !== want) begin errors++; $display("FAIL fwd_exmem_in1 obs=%h exp=%h", bus.ex_alu_in_1, want); end
    bus.fwd_exmem_we = 1'b0;
    #1;
`ifdef FORWARDING_EN
    want = 32'hBB;
`else
    want = 32'h11;
`endif
    sb.push_back(model_out());
    exp = sb.pop_front(); obs = sample(); checks++;
    if (obs !== exp || bus.ex_alu_in_1 !== want) begin
      errors++; $display("FAIL fwd_memwb obs=%h exp=%h in1=%h want=%h", obs, exp, bus.ex_alu_in_1, want);
    end
    bus.id_rs1_addr = 5'd0; bus.id_rs1_data = 32'h33;
    bus.fwd_exmem_we = 1'b1; bus.fwd_exmem_rd = 5'd0; bus.fwd_memwb_rd = 5'd0;
    step();
    exp = sb.pop_front(); obs = sample(); checks++;
    if (obs !== exp || bus.ex_alu_in_1 !== 32'h33) begin
      errors++; $display("FAIL fwd_x0 obs=%h exp=%h in1=%h want=33", obs, exp, bus.ex_alu_in_1);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      random_id(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      bus.stall          = ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0;
      bus.flush          = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
      bus.fwd_exmem_we   = 1'($urandom_range(0, 1));
      bus.fwd_memwb_we   = 1'($urandom_range(0, 1));
      bus.fwd_exmem_rd   = 5'($urandom_range(0, 7));
      bus.fwd_memwb_rd   = 5'($urandom_range(0, 7));
      bus.fwd_exmem_data = $urandom;
      bus.fwd_memwb_data = $urandom;
      step();
      exp = sb.pop_front(); obs = sample(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL b2b[%0d] obs=%h exp=%h", i, obs, exp); end
    end
    bus.stall = 1'b1; bus.flush = 1'b0;
  endtask

  task automatic test_saturation();
    int want;
    bus_s.stall = 1'b0;
    bus_s.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sb_cnt.push_back((i + 1 > 3) ? 3 : i + 1);
      @(posedge clk);
      #1;
      want = sb_cnt.pop_front();
      checks++;
      if (int'(bus_s.bubble_count) !== want) begin
        errors++; $display("FAIL sat_count[%0d] obs=%0d exp=%0d", i, bus_s.bubble_count, want);
      end
    end
    bus_s.stall = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_bub  = '0;
    test_reset();
    test_load();
    test_stall();
    test_forwarding();
    test_back_to_back();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
